fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC register, next-PC selection and F/D pipeline register for the five-stage MIPS core.
- Consumes the D-stage branch decision (D_bjump) and the D-stage jump controls.
- Produces F_PC for instruction memory, and the D_instr/D_PC pair that feeds decode and the D-stage comparator.
- Implements MIPS delayed branching: one delay slot, never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC and the F/D register.
- F_instr  in  32  instruction read from IM at F_PC.
- D_NPCOp  in  2  0=PC+4, 1=BRANCH, 2=J/JAL, 3=JR; decoded from D_instr.
- D_bjump  in  1  branch condition from the D comparator; used only when D_NPCOp=BRANCH.
- D_jr_target  in  32  forwarded rs value for JR/JALR.
- F_PC  out  32  current fetch address.
- F_pc_err  out  1  F_PC misaligned or outside the IM range (combinational from F_PC).
- D_instr  out  32  registered instruction in D.
- D_PC  out  32  registered PC of D_instr.
- D_PC8  out  32  D_PC+8, link value for JAL/JALR.
- D_exc_adel  out  1  registered fetch-error flag accompanying D_instr.

Behaviour:
- Reset (synchronous, wins over stall): F_PC=RESET_PC, D_instr=0 (nop), D_PC=0, D_exc_adel=0. D_PC8 = D_PC+8 = 8 during reset. A reset mid-operation discards any pending redirect.
- NPC computation (combinational):
  - PC+4 → F_PC+4.
  - BRANCH with D_bjump=1 → D_PC+4+(sign_extend(D_instr[15:0])<<2).
  - BRANCH with D_bjump=0 → F_PC+4.
  - J/JAL → {D_PC[31:28], D_instr[25:0], 2'b00}.
  - JR → D_jr_target.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- Normal cycle (stall=0):
  - F_PC<=NPC.
  - D_instr<=F_pc_err ? 0 : F_instr.
  - D_PC<=F_PC.
  - D_exc_adel<=F_pc_err.
- Stall cycle (stall=1): F_PC, D_instr, D_PC and D_exc_adel all hold. No redirect is latched internally. The D-stage branch is re-evaluated every cycle and takes effect on the first non-stalled edge, so forwarded operands that change during the stall are honoured.
- Delay slot: the instruction in F while a branch or jump is in D is always loaded into D (never squashed), including when the branch is not taken.
- Redirect latency: the target appears on F_PC exactly one edge after the branch's first non-stalled cycle in D.
- F_pc_err = (F_PC[1:0]!=0) | (F_PC<IM_BASE) | (F_PC>=IM_BASE+4*IM_WORDS).
  - The faulting fetch enters D as a nop with D_exc_adel=1.
  - PC sequencing continues normally; the exception unit handles recovery.
- Illegal D_NPCOp values are impossible by encoding. A stall asserted during reset is ignored.

Test Plan:
- Reset then 3 free-running cycles, stall=0, D_NPCOp=0 → F_PC 0x3000, 0x3004, 0x3008, 0x300C; D_PC lags F_PC by one cycle; D_instr tracks F_instr.
- Taken beq: D_PC=0x3004, D_instr[15:0]=0x0003, D_NPCOp=1, D_bjump=1 → next F_PC=0x3014; the delay slot at 0x3008 enters D. Same case with D_bjump=0 → F_PC=0x300C.
- Backward branch: imm=0xFFFF at D_PC=0x3010, taken → F_PC=0x3010.
- j at D_PC=0x3000, D_instr[25:0]=0x0000C10, D_NPCOp=2 → F_PC=0x0000_3040. jal: D_PC8=0x3008.
- Stall 3 cycles while a taken beq sits in D → F_PC, D_PC and D_instr are frozen. After release, the redirect lands on the first edge. Reset asserted during the stall → F_PC=0x3000.
- jr with D_jr_target=0x3101 → F_PC=0x3101 and F_pc_err=1; next cycle D_instr=0, D_exc_adel=1. Target 0x7000 → F_pc_err=1 (out of range).

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, next-PC select and F/D pipeline register.
// Ports: clk/reset/stall, F_instr in; D_NPCOp/D_bjump/D_jr_target in;
// F_PC/F_pc_err out; D_instr/D_PC/D_PC8/D_exc_adel out (F/D register).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic [1:0]  D_NPCOp,
    input  logic        D_bjump,
    input  logic [31:0] D_jr_target,
    output logic [31:0] F_PC,
    output logic        F_pc_err,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_PC8,
    output logic        D_exc_adel
);

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // End bound kept at 33 bits so a range ending at 2^32 still compares.
    localparam logic [32:0] IM_END =
        33'(IM_BASE) + 33'(4 * IM_WORDS);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] npc;

    assign pc_plus4 = F_PC + 32'd4;
    assign br_off   = {{14{D_instr[15]}}, D_instr[15:0], 2'b00};

    // The branch is evaluated from D every cycle; no redirect is
    // latched, so a stall simply re-evaluates with fresh operands.
    always_comb begin
        npc = pc_plus4;
        unique case (D_NPCOp)
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = D_bjump ? (D_PC + 32'd4 + br_off)
                                   : pc_plus4;
            NPC_J:   npc = {D_PC[31:28], D_instr[25:0], 2'b00};
            NPC_JR:  npc = D_jr_target;
        endcase
    end

    assign F_pc_err = (F_PC[1:0] != 2'b00)
                    | (F_PC < IM_BASE)
                    | ({1'b0, F_PC} >= IM_END);

    // Delay slot is never squashed: whatever sits in F always moves
    // into D on a non-stalled edge. A faulting fetch becomes a nop.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC       <= RESET_PC;
            D_instr    <= 32'd0;
            D_PC       <= 32'd0;
            D_exc_adel <= 1'b0;
        end else if (!stall) begin
            F_PC       <= npc;
            D_instr    <= F_pc_err ? 32'd0 : F_instr;
            D_PC       <= F_PC;
            D_exc_adel <= F_pc_err;
        end
    end

    assign D_PC8 = D_PC + 32'd8;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: reference model plus directed vectors.
// Model is compared on every cycle; literals pin key addresses.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] F_instr;
    logic [1:0]  D_NPCOp;
    logic        D_bjump;
    logic [31:0] D_jr_target;
    logic [31:0] F_PC;
    logic        F_pc_err;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic [31:0] D_PC8;
    logic        D_exc_adel;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic chk_en = 1'b0;

    // Reference state
    logic [31:0] m_pc, m_dpc, m_di;
    logic        m_adel;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .F_instr(F_instr), .D_NPCOp(D_NPCOp),
        .D_bjump(D_bjump), .D_jr_target(D_jr_target),
        .F_PC(F_PC), .F_pc_err(F_pc_err),
        .D_instr(D_instr), .D_PC(D_PC), .D_PC8(D_PC8),
        .D_exc_adel(D_exc_adel)
    );

    function automatic logic [31:0] im(input logic [31:0] a);
        case (a)
            32'h3000: im = 32'h0800_0C10;
            32'h3004: im = 32'h1000_0003;
            32'h3010: im = 32'h1000_FFFF;
            default:  im = 32'h2000_0000 | {16'd0, a[15:0]};
        endcase
    endfunction

    assign F_instr = im(F_PC);

    function automatic bit bad(input logic [31:0] a);
        longint la;
        la = longint'(a);
        bad = (la % 4 != 0) || (la < 64'h3000)
           || (la >= 64'h3000 + 4 * 4096);
    endfunction

    function automatic logic [31:0] model_npc();
        longint t;
        int     imm;
        case (D_NPCOp)
            2'd1: begin
                imm = int'($signed(m_di[15:0]));
                if (D_bjump)
                    t = longint'(m_dpc) + 4 + 4 * longint'(imm);
                else
                    t = longint'(m_pc) + 4;
            end
            2'd2: t = longint'(m_dpc & 32'hF000_0000)
                    + 4 * longint'(m_di & 32'h03FF_FFFF);
            2'd3: t = longint'(D_jr_target);
            default: t = longint'(m_pc) + 4;
        endcase
        model_npc = t[31:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc   <= 32'h3000;
            m_dpc  <= 32'd0;
            m_di   <= 32'd0;
            m_adel <= 1'b0;
        end else if (!stall) begin
            m_pc   <= model_npc();
            m_dpc  <= m_pc;
            m_di   <= bad(m_pc) ? 32'd0 : im(m_pc);
            m_adel <= bad(m_pc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("F_PC", F_PC, m_pc);
            chk("F_pc_err", {31'd0, F_pc_err},
                {31'd0, bad(m_pc)});
            chk("D_instr", D_instr, m_di);
            chk("D_PC", D_PC, m_dpc);
            chk("D_PC8", D_PC8, m_dpc + 32'd8);
            chk("D_exc_adel", {31'd0, D_exc_adel}, {31'd0, m_adel});
        end
    end

    // Literal pin: both DUT and model must hit the hand value.
    task automatic pin(input string nm, input logic [31:0] act,
                       input logic [31:0] mdl,
                       input logic [31:0] exp);
        chk({nm, "_lit"}, act, exp);
        chk({nm, "_mdl"}, mdl, exp);
    endtask

    task automatic cyc(input logic [1:0] op, input logic bj,
                       input logic [31:0] jr, input logic st);
        D_NPCOp = op;
        D_bjump = bj;
        D_jr_target = jr;
        stall = st;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        D_NPCOp = 2'd0;
        D_bjump = 1'b0;
        D_jr_target = 32'd0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset state and sequential fetch
        do_reset();
        pin("rst_pc", F_PC, m_pc, 32'h3000);
        pin("rst_di", D_instr, m_di, 32'd0);
        chk("rst_pc8", D_PC8, 32'd8);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("seq1", F_PC, m_pc, 32'h3004);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("seq2", F_PC, m_pc, 32'h3008);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("seq3", F_PC, m_pc, 32'h300C);
        pin("seq3_dpc", D_PC, m_dpc, 32'h3008);

        // Taken beq at 0x3004, imm 3
        do_reset();
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("beq_di", D_instr, m_di, 32'h1000_0003);
        cyc(2'd1, 1'b1, 32'd0, 1'b0);
        pin("beq_t", F_PC, m_pc, 32'h3014);
        pin("beq_slot", D_PC, m_dpc, 32'h3008);

        // Not taken
        do_reset();
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd1, 1'b0, 32'd0, 1'b0);
        pin("beq_nt", F_PC, m_pc, 32'h300C);
        pin("nt_slot", D_PC, m_dpc, 32'h3008);

        // Backward branch at 0x3010, imm -1
        do_reset();
        repeat (5) cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("bk_dpc", D_PC, m_dpc, 32'h3010);
        cyc(2'd1, 1'b1, 32'd0, 1'b0);
        pin("bk", F_PC, m_pc, 32'h3010);

        // j / jal at 0x3000
        do_reset();
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("jal_pc8", D_PC8, m_dpc + 32'd8, 32'h3008);
        cyc(2'd2, 1'b0, 32'd0, 1'b0);
        pin("j", F_PC, m_pc, 32'h3040);

        // Stall with taken beq in D
        do_reset();
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        repeat (3) cyc(2'd1, 1'b1, 32'd0, 1'b1);
        pin("stl_pc", F_PC, m_pc, 32'h3008);
        pin("stl_dpc", D_PC, m_dpc, 32'h3004);
        pin("stl_di", D_instr, m_di, 32'h1000_0003);
        cyc(2'd1, 1'b1, 32'd0, 1'b0);
        pin("stl_rel", F_PC, m_pc, 32'h3014);

        // Reset wins over stall, drops pending branch
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;
        cyc(2'd1, 1'b1, 32'd0, 1'b1);
        reset = 1'b0;
        pin("rst_stl", F_PC, m_pc, 32'h3000);
        pin("rst_stl_dpc", D_PC, m_dpc, 32'd0);

        // jr to misaligned / out-of-range / edge targets
        do_reset();
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        cyc(2'd3, 1'b0, 32'h3101, 1'b0);
        pin("jr_mis", F_PC, m_pc, 32'h3101);
        chk("jr_mis_err", {31'd0, F_pc_err}, 32'd1);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        pin("adel_di", D_instr, m_di, 32'd0);
        chk("adel_flag", {31'd0, D_exc_adel}, 32'd1);
        pin("adel_dpc", D_PC, m_dpc, 32'h3101);
        cyc(2'd3, 1'b0, 32'h7000, 1'b0);
        chk("oor_err", {31'd0, F_pc_err}, 32'd1);
        cyc(2'd3, 1'b0, 32'h6FFC, 1'b0);
        chk("top_ok", {31'd0, F_pc_err}, 32'd0);
        chk("top_adel", {31'd0, D_exc_adel}, 32'd1);
        cyc(2'd3, 1'b0, 32'h2FFC, 1'b0);
        chk("low_err", {31'd0, F_pc_err}, 32'd1);
        chk("low_adel", {31'd0, D_exc_adel}, 32'd0);
        cyc(2'd0, 1'b0, 32'd0, 1'b0);
        chk("low_d", {31'd0, D_exc_adel}, 32'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
